// File: rtl/mips_interlock_ctrl.sv
// Scoreboard issue controller between ID and EX. It stalls reads of registers that are
// still being written and sequences HLT through a drain phase into a sticky halted state.
module mips_interlock_ctrl #(
    parameter int NREGS  = 32,
    parameter int RA_W   = 5,
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_halt,
    input  logic             flush,
    output logic             id_issue,
    output logic             stall,
    output logic             draining,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int SB_W = $clog2(WB_LAT + 1);
    localparam logic [SB_W-1:0] LAT = SB_W'(WB_LAT);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t          state, state_next;
    logic [SB_W-1:0] drain_cnt, drain_next;
    logic [SB_W-1:0] sb [NREGS];
    logic            rs_busy, rt_busy, hazard, run;

    assign rs_busy  = id_use_rs && (id_rs != '0) && (sb[id_rs] != '0);
    assign rt_busy  = id_use_rt && (id_rt != '0) && (sb[id_rt] != '0);
    assign hazard   = rs_busy || rt_busy;
    assign run      = (state == RUN);
    assign id_issue = id_valid && !flush && !hazard && run;
    assign stall    = id_valid && !flush && hazard && run;
    assign draining = (state == DRAIN);
    assign halted   = (state == HALTED);

    // A fresh write load takes priority over the per-cycle countdown; R0 never goes busy.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) sb[i] <= '0;
        end else begin
            sb[0] <= '0;
            for (int i = 1; i < NREGS; i++) begin
                if (id_issue && id_wr_en && (id_rd == RA_W'(i)))
                    sb[i] <= LAT;
                else if (sb[i] != '0)
                    sb[i] <= sb[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= '0;
            stall_count <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

    // The drain phase lasts WB_LAT cycles: leave it on the edge where the counter would reach 0.
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        case (state)
            RUN: begin
                if (id_issue && id_halt) begin
                    state_next = DRAIN;
                    drain_next = LAT;
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_next = RUN;
                    drain_next = '0;
                end else if (drain_cnt <= SB_W'(1)) begin
                    state_next = HALTED;
                    drain_next = '0;
                end else begin
                    drain_next = drain_cnt - 1'b1;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
                drain_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_interlock_ctrl.sv
// Bench for mips_interlock_ctrl: fixed vector table, hand-written halt/flush/reset sequences,
// and random traffic checked against a cycle-number based model of register readiness.
module tb_mips_interlock_ctrl;

    localparam int WB_LAT = 3;
    localparam int CNT_W  = 16;

    logic             clk1 = 1'b0;
    logic             rst;
    logic             id_valid, id_use_rs, id_use_rt, id_wr_en, id_halt, flush;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic             id_issue, stall, draining, halted;
    logic [CNT_W-1:0] stall_count;

    mips_interlock_ctrl #(.NREGS(32), .RA_W(5), .WB_LAT(WB_LAT), .CNT_W(CNT_W)) dut (
        .clk1(clk1), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_halt(id_halt), .flush(flush), .id_issue(id_issue), .stall(stall),
        .draining(draining), .halted(halted), .stall_count(stall_count)
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;

    // Model: a register is readable from cycle ready_at[r]; mode 0=run, 1=drain, 2=halted.
    int   ready_at [32];
    int   cyc, mode, halt_at, m_count;
    logic e_issue, e_stall, e_drain, e_halt;

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic       use_rs, use_rt, wr;
        logic [4:0] rd;
        logic       halt, fl;
        logic       exp_issue, exp_stall;
        int         exp_cnt;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(logic v, int rs, int rt, logic urs, logic urt, logic wr, int rd,
                                logic fl, logic ei, logic es, int ec);
        vec_t t;
        t.valid = v;  t.rs = 5'(rs);  t.rt = 5'(rt);  t.use_rs = urs;  t.use_rt = urt;
        t.wr = wr;  t.rd = 5'(rd);  t.halt = 1'b0;  t.fl = fl;
        t.exp_issue = ei;  t.exp_stall = es;  t.exp_cnt = ec;
        return t;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        cyc = 0;  mode = 0;  halt_at = 0;  m_count = 0;
    endfunction

    function automatic void model_eval();
        logic hz;
        hz = (id_use_rs && id_rs != 0 && ready_at[id_rs] > cyc) ||
             (id_use_rt && id_rt != 0 && ready_at[id_rt] > cyc);
        e_issue = id_valid && !flush && !hz && (mode == 0);
        e_stall = id_valid && !flush && hz && (mode == 0);
        e_drain = (mode == 1);
        e_halt  = (mode == 2);
    endfunction

    function automatic void model_advance();
        if (mode == 1) begin
            if (flush) mode = 0;
            else if (cyc >= halt_at + WB_LAT) mode = 2;
        end else if (mode == 0 && e_issue && id_halt) begin
            mode = 1;
            halt_at = cyc;
        end
        if (e_issue && id_wr_en && id_rd != 0) ready_at[id_rd] = cyc + WB_LAT + 1;
        if (e_stall && m_count < 65535) m_count++;
        cyc++;
    endfunction

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic wr,
                                 input logic [4:0] rd, input logic h, input logic fl);
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;
        id_wr_en = wr;  id_rd = rd;  id_halt = h;  flush = fl;
        #4;
        model_eval();
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, ".id_issue"}, 32'(id_issue), 32'(e_issue));
        compare({tag, ".stall"}, 32'(stall), 32'(e_stall));
        compare({tag, ".draining"}, 32'(draining), 32'(e_drain));
        compare({tag, ".halted"}, 32'(halted), 32'(e_halt));
        compare({tag, ".stall_count"}, 32'(stall_count), 32'(m_count));
    endtask

    task automatic advance();
        @(posedge clk1);
        #1;
        model_advance();
    endtask

    task automatic step(input string tag, input logic v, input int rs, input int rt,
                        input logic urs, input logic urt, input logic wr, input int rd,
                        input logic h, input logic fl);
        applyStimulus(v, 5'(rs), 5'(rt), urs, urt, wr, 5'(rd), h, fl);
        checkOutput(tag);
        advance();
    endtask

    // Called at posedge+1; rst rises 'offset' later, between clock edges.
    task automatic do_reset(input string tag, input int offset);
        id_valid = 1'b0;  id_halt = 1'b0;  flush = 1'b0;  id_wr_en = 1'b0;
        #(offset);
        rst = 1'b1;
        #1;
        compare({tag, ".rst_draining"}, 32'(draining), 32'd0);
        compare({tag, ".rst_halted"}, 32'(halted), 32'd0);
        compare({tag, ".rst_stall_count"}, 32'(stall_count), 32'd0);
        @(posedge clk1);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int drain_seen;
        rst = 1'b1;
        id_valid = 0;  id_rs = 0;  id_rt = 0;  id_use_rs = 0;  id_use_rt = 0;
        id_wr_en = 0;  id_rd = 0;  id_halt = 0;  flush = 0;
        #2;
        compare("init.draining", 32'(draining), 32'd0);
        compare("init.halted", 32'(halted), 32'd0);
        compare("init.stall_count", 32'(stall_count), 32'd0);
        @(posedge clk1);
        #1;
        rst = 1'b0;
        model_reset();

        // Back-to-back RAW, distance-3 RAW, R0 traffic, idle slot, flush over a stall.
        tbl[0]  = mk(1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0);
        tbl[1]  = mk(1, 0, 0, 1, 0, 1, 2, 0, 1, 0, 0);
        tbl[2]  = mk(1, 1, 2, 1, 1, 1, 4, 0, 0, 1, 0);
        tbl[3]  = mk(1, 1, 2, 1, 1, 1, 4, 0, 0, 1, 1);
        tbl[4]  = mk(1, 1, 2, 1, 1, 1, 4, 0, 0, 1, 2);
        tbl[5]  = mk(1, 1, 2, 1, 1, 1, 4, 0, 1, 0, 3);
        tbl[6]  = mk(1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 3);
        tbl[7]  = mk(1, 0, 0, 1, 0, 1, 6, 0, 1, 0, 3);
        tbl[8]  = mk(1, 0, 0, 1, 0, 1, 7, 0, 1, 0, 3);
        tbl[9]  = mk(1, 1, 1, 1, 1, 1, 4, 0, 0, 1, 3);
        tbl[10] = mk(1, 1, 1, 1, 1, 1, 4, 0, 1, 0, 4);
        tbl[11] = mk(1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 4);
        tbl[12] = mk(1, 0, 0, 1, 1, 1, 8, 0, 1, 0, 4);
        tbl[13] = mk(0, 5, 5, 1, 1, 1, 9, 0, 0, 0, 4);
        tbl[14] = mk(1, 0, 0, 1, 0, 1, 3, 0, 1, 0, 4);
        tbl[15] = mk(1, 3, 0, 1, 0, 1, 10, 1, 0, 0, 4);
        tbl[16] = mk(1, 3, 0, 1, 0, 1, 10, 0, 0, 1, 4);
        tbl[17] = mk(1, 3, 0, 1, 0, 1, 10, 0, 0, 1, 5);
        tbl[18] = mk(1, 3, 0, 1, 0, 1, 10, 0, 1, 0, 6);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].use_rs, tbl[i].use_rt,
                          tbl[i].wr, tbl[i].rd, tbl[i].halt, tbl[i].fl);
            checkOutput($sformatf("tbl%0d", i));
            compare($sformatf("tbl%0d.issue", i), 32'(id_issue), 32'(tbl[i].exp_issue));
            compare($sformatf("tbl%0d.stall", i), 32'(stall), 32'(tbl[i].exp_stall));
            compare($sformatf("tbl%0d.count", i), 32'(stall_count), 32'(tbl[i].exp_cnt));
            advance();
        end

        // HLT after a write: three drain cycles, then sticky halt with a valid instruction held.
        do_reset("pre_halt", 0);
        step("halt_w4", 1, 0, 0, 1, 0, 1, 4, 0, 0);
        step("halt_add", 1, 3, 3, 1, 1, 1, 5, 0, 0);
        step("halt_hlt", 1, 0, 0, 0, 0, 0, 0, 1, 0);
        drain_seen = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 5'd5, 5'd4, 1, 1, 1, 5'd6, 0, 0);
            checkOutput($sformatf("halt_hold%0d", i));
            if (draining) drain_seen++;
            advance();
        end
        compare("halt.drain_len", 32'(drain_seen), 32'd3);
        compare("halt.sticky", 32'(halted), 32'd1);

        // HLT squashed by a flush on the next cycle.
        do_reset("pre_flush", 0);
        step("fh_hlt", 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step("fh_flush", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step("fh_next", 1, 0, 0, 1, 0, 1, 2, 0, 0);
        step("fh_more", 1, 0, 0, 1, 0, 1, 3, 0, 0);
        compare("fh.halted", 32'(halted), 32'd0);

        // Asynchronous reset during drain, then during a stall.
        step("ar_hlt", 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step("ar_drain", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset("ar_mid_drain", 2);
        step("ar_w1", 1, 0, 0, 1, 0, 1, 1, 0, 0);
        step("ar_st0", 1, 1, 0, 1, 0, 1, 2, 0, 0);
        step("ar_st1", 1, 1, 0, 1, 0, 1, 2, 0, 0);
        do_reset("ar_mid_stall", 3);
        applyStimulus(1, 5'd1, 5'd1, 1, 1, 1, 5'd2, 0, 0);
        checkOutput("ar_after");
        compare("ar_after.issue", 32'(id_issue), 32'd1);
        advance();

        // Random traffic on a small register window to provoke frequent hazards.
        for (int i = 0; i < 400; i++) begin
            if (mode == 2 && $urandom_range(0, 3) == 0)
                do_reset("rnd_rst", int'($urandom_range(0, 3)));
            step($sformatf("rnd%0d", i), ($urandom_range(0, 9) < 8),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
